dispatch_ctrl: RTL and testbench
================================

# dispatch_ctrl

Credit-based dispatch scheduler between the decode output buffer and the backend queues (ALU RS, branch RS, load/store queue, ROB, physical-register free list). Each cycle it decides whether the decoded instruction can leave decode, steers it to exactly one issue queue by `uop_class`, and allocates ROB and PRF resources. It tracks free entries per queue with credit counters and blocks dispatch for a fixed window after a redirect.

## Interface
- `ALU_RS_DEPTH`, 8: ALU reservation-station entries (credits).
- `BR_RS_DEPTH`, 4: branch/jump reservation-station entries.
- `LSQ_DEPTH`, 8: load/store queue entries.
- `ROB_DEPTH`, 16: ROB entries.
- `FLUSH_CYCLES`, 2: dispatch-blocked cycles after a redirect; range 1..15.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `redirect_valid` in 1: pipeline redirect/flush pulse.
- `decode_valid` in 1: decoded bundle available.
- `decoded_bundle_fields` in `decoded_bundle_t`: uses `uop_class`, `uses_rd`.
- `decode_ready` out 1: dispatch accepts the bundle this cycle.
- `alu_disp_valid`, `br_disp_valid`, `lsu_disp_valid` out 1 each: one-hot steer pulses.
- `rob_alloc_valid` out 1: allocate a ROB entry.
- `prf_alloc_valid` out 1: pop the free list.
- `freelist_empty` in 1: no free physical register.
- `alu_credit_ret`, `br_credit_ret`, `lsu_credit_ret`, `rob_credit_ret` in 1 each: one entry freed this cycle.
- `stall_rob_cnt`, `stall_rs_cnt`, `stall_prf_cnt`, `flush_cyc_cnt` out 32 each: performance counters.

## Operation
- Target queue by class:
  - `UOP_ALU` → ALU.
  - `UOP_BRANCH`, `UOP_JUMP` → BR.
  - `UOP_LOAD`, `UOP_STORE` → LSQ.
  - `UOP_MISC` (including illegal) → ROB only; needs no RS credit.
- Credit counters are `$clog2(DEPTH+1)` bits and reset to DEPTH.
- `decode_ready` = state RUN && !redirect_valid && rob_cred≠0 && target_cred≠0 (MISC: always true) && (!uses_rd || !freelist_empty).
- `fire` = decode_valid && decode_ready. On `fire`:
  - The target dispatch valid asserts.
  - `rob_alloc_valid` asserts.
  - `prf_alloc_valid` = uses_rd.
- All outputs other than the counters are 0 when not firing.
- Counter update per queue: next = cnt − (dispatch to it) + ret.
  - Dispatch and return in the same cycle leave the count unchanged.
  - A return while cnt==DEPTH is ignored (saturate) and flagged by a simulation assertion.
  - Dispatch never occurs at cnt==0.
- Returns are accepted in every state.
- FSM:
  - RUN: on `redirect_valid`, go to FLUSH and load `flush_ctr` = FLUSH_CYCLES−1.
  - FLUSH: `decode_ready`=0. `flush_ctr` decrements each cycle. Go to RUN when `flush_ctr`==0 and !redirect_valid.
  - `redirect_valid` during FLUSH reloads `flush_ctr` to FLUSH_CYCLES−1.
- Redirect does not reset credits; the backend returns flushed entries through the `*_credit_ret` ports.

## Timing
- Reset values:
  - FSM = RUN; credits = DEPTH values; `flush_ctr` = 0; all perf counters 0.
  - `decode_ready` then follows its equation: 1 once credits are available, 0 in the reset cycle only if `freelist_empty`&&uses_rd.
  - All dispatch and alloc outputs = 0.
- Dispatch outputs are combinational in the fire cycle (0-cycle latency). Credit changes are visible from the next cycle.
- A credit returned in cycle N enables dispatch in cycle N+1; there is no same-cycle bypass.
- A redirect in cycle N blocks dispatch in N (combinational) and in N+1..N+FLUSH_CYCLES. RUN resumes in cycle N+FLUSH_CYCLES+1.
- Asynchronous reset mid-operation immediately restores all reset values, discarding credits in flight.

## Configuration
- `DISPATCH_PERF_EN` defined:
  - When decode_valid && !decode_ready in RUN, exactly one stall counter increments, by priority: ROB credit → `stall_rob_cnt`; RS credit → `stall_rs_cnt`; free list → `stall_prf_cnt`.
  - `flush_cyc_cnt` increments on every cycle in FLUSH.
  - All counters wrap at 2^32.
- Not defined: the counters are tied to 0 and no counter flops are synthesized.

## Test plan
- 9 back-to-back ALU uops, no returns → 8 fire, `alu_disp_valid` and `rob_alloc_valid` each 8 pulses; the 9th stalls with `decode_ready`=0. One `alu_credit_ret` → the 9th fires in the next cycle.
- ALU dispatch and `alu_credit_ret` in the same cycle with ALU credit=1 → credit stays 1; the next ALU uop fires.
- `redirect_valid` in cycle 10 with FLUSH_CYCLES=2 → `decode_ready`=0 in cycles 10–12 and 1 in cycle 13. A second redirect in cycle 11 extends the block through cycle 13.
- uses_rd=1 with `freelist_empty`=1 → no fire and `stall_prf_cnt` +1 per cycle (PERF_EN). uses_rd=0 with the same inputs → fires, `prf_alloc_valid`=0.
- 17 MISC uops, no returns → 16 fire with no RS pulses; the 17th stalls and increments `stall_rob_cnt`.
- Assert `rst_n` low mid-stall with ALU credit=0 → all credits immediately DEPTH and the FSM in RUN; after release, an ALU uop fires.

Source files
------------

// File: rtl/dispatch_ctrl.sv
// Credit-based dispatch scheduler: steers decoded uops to ALU/BR/LSQ, allocates ROB/PRF, blocks after redirects.
// Optional perf counters are built only when DISPATCH_PERF_EN is defined; otherwise they read as zero.
package dispatch_pkg;
  typedef enum logic [2:0] {
    UOP_ALU    = 3'd0,
    UOP_BRANCH = 3'd1,
    UOP_JUMP   = 3'd2,
    UOP_LOAD   = 3'd3,
    UOP_STORE  = 3'd4,
    UOP_MISC   = 3'd5
  } uop_class_e;

  typedef struct packed {
    uop_class_e uop_class;
    logic       uses_rd;
  } decoded_bundle_t;
endpackage

module dispatch_ctrl
  import dispatch_pkg::*;
#(
  parameter int ALU_RS_DEPTH = 8,
  parameter int BR_RS_DEPTH  = 4,
  parameter int LSQ_DEPTH    = 8,
  parameter int ROB_DEPTH    = 16,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid,
  input  logic            decode_valid,
  input  decoded_bundle_t decoded_bundle_fields,
  output logic            decode_ready,
  output logic            alu_disp_valid,
  output logic            br_disp_valid,
  output logic            lsu_disp_valid,
  output logic            rob_alloc_valid,
  output logic            prf_alloc_valid,
  input  logic            freelist_empty,
  input  logic            alu_credit_ret,
  input  logic            br_credit_ret,
  input  logic            lsu_credit_ret,
  input  logic            rob_credit_ret,
  output logic [31:0]     stall_rob_cnt,
  output logic [31:0]     stall_rs_cnt,
  output logic [31:0]     stall_prf_cnt,
  output logic [31:0]     flush_cyc_cnt
);
  localparam int AW = $clog2(ALU_RS_DEPTH + 1);
  localparam int BW = $clog2(BR_RS_DEPTH + 1);
  localparam int LW = $clog2(LSQ_DEPTH + 1);
  localparam int RW = $clog2(ROB_DEPTH + 1);
  localparam logic [AW-1:0] ALU_FULL = AW'(ALU_RS_DEPTH);
  localparam logic [BW-1:0] BR_FULL  = BW'(BR_RS_DEPTH);
  localparam logic [LW-1:0] LSQ_FULL = LW'(LSQ_DEPTH);
  localparam logic [RW-1:0] ROB_FULL = RW'(ROB_DEPTH);
  localparam logic [3:0]    FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  // state    | meaning
  // ST_RUN   | dispatch allowed when credits and free list permit
  // ST_FLUSH | post-redirect window, dispatch blocked until flush_ctr drains
  typedef enum logic {ST_RUN, ST_FLUSH} state_e;

  state_e          state_q, state_d;
  logic [3:0]      flush_ctr_q, flush_ctr_d;
  logic [AW-1:0]   alu_cred_q, alu_cred_d;
  logic [BW-1:0]   br_cred_q, br_cred_d;
  logic [LW-1:0]   lsu_cred_q, lsu_cred_d;
  logic [RW-1:0]   rob_cred_q, rob_cred_d;
  logic            is_alu, is_br, is_lsu, target_ok, fire;

  always_comb begin
    is_alu = 1'b0;
    is_br  = 1'b0;
    is_lsu = 1'b0;
    case (decoded_bundle_fields.uop_class)
      UOP_ALU:              is_alu = 1'b1;
      UOP_BRANCH, UOP_JUMP: is_br  = 1'b1;
      UOP_LOAD, UOP_STORE:  is_lsu = 1'b1;
      default: ;
    endcase
  end

  // MISC and illegal classes only need a ROB entry
  assign target_ok = is_alu ? (alu_cred_q != '0) :
                     is_br  ? (br_cred_q  != '0) :
                     is_lsu ? (lsu_cred_q != '0) : 1'b1;

  assign decode_ready = (state_q == ST_RUN) && !redirect_valid && (rob_cred_q != '0) &&
                        target_ok && (!decoded_bundle_fields.uses_rd || !freelist_empty);
  assign fire            = decode_valid && decode_ready;
  assign alu_disp_valid  = fire && is_alu;
  assign br_disp_valid   = fire && is_br;
  assign lsu_disp_valid  = fire && is_lsu;
  assign rob_alloc_valid = fire;
  assign prf_alloc_valid = fire && decoded_bundle_fields.uses_rd;

  // Returns at full are dropped so the counters never exceed depth
  always_comb begin
    alu_cred_d = alu_cred_q - AW'(alu_disp_valid)  + AW'(alu_credit_ret && (alu_cred_q != ALU_FULL));
    br_cred_d  = br_cred_q  - BW'(br_disp_valid)   + BW'(br_credit_ret  && (br_cred_q  != BR_FULL));
    lsu_cred_d = lsu_cred_q - LW'(lsu_disp_valid)  + LW'(lsu_credit_ret && (lsu_cred_q != LSQ_FULL));
    rob_cred_d = rob_cred_q - RW'(rob_alloc_valid) + RW'(rob_credit_ret && (rob_cred_q != ROB_FULL));
  end

  always_comb begin
    state_d     = state_q;
    flush_ctr_d = flush_ctr_q;
    case (state_q)
      ST_RUN: begin
        if (redirect_valid) begin
          state_d     = ST_FLUSH;
          flush_ctr_d = FLUSH_LOAD;
        end
      end
      ST_FLUSH: begin
        if (redirect_valid)          flush_ctr_d = FLUSH_LOAD;
        else if (flush_ctr_q == '0)  state_d     = ST_RUN;
        else                         flush_ctr_d = flush_ctr_q - 4'd1;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      flush_ctr_q <= '0;
      alu_cred_q  <= ALU_FULL;
      br_cred_q   <= BR_FULL;
      lsu_cred_q  <= LSQ_FULL;
      rob_cred_q  <= ROB_FULL;
    end else begin
      state_q     <= state_d;
      flush_ctr_q <= flush_ctr_d;
      alu_cred_q  <= alu_cred_d;
      br_cred_q   <= br_cred_d;
      lsu_cred_q  <= lsu_cred_d;
      rob_cred_q  <= rob_cred_d;
    end
  end

  a_alu_ret_full: assert property (@(posedge clk) disable iff (!rst_n) !(alu_credit_ret && alu_cred_q == ALU_FULL));
  a_br_ret_full:  assert property (@(posedge clk) disable iff (!rst_n) !(br_credit_ret  && br_cred_q  == BR_FULL));
  a_lsu_ret_full: assert property (@(posedge clk) disable iff (!rst_n) !(lsu_credit_ret && lsu_cred_q == LSQ_FULL));
  a_rob_ret_full: assert property (@(posedge clk) disable iff (!rst_n) !(rob_credit_ret && rob_cred_q == ROB_FULL));

`ifdef DISPATCH_PERF_EN
  logic [31:0] stall_rob_q, stall_rob_d, stall_rs_q, stall_rs_d;
  logic [31:0] stall_prf_q, stall_prf_d, flush_cyc_q, flush_cyc_d;

  // Exactly one stall cause is charged, ROB first, then RS, then free list
  always_comb begin
    stall_rob_d = stall_rob_q;
    stall_rs_d  = stall_rs_q;
    stall_prf_d = stall_prf_q;
    flush_cyc_d = flush_cyc_q;
    if ((state_q == ST_RUN) && decode_valid && !decode_ready) begin
      if (rob_cred_q == '0)                                          stall_rob_d = stall_rob_q + 32'd1;
      else if (!target_ok)                                           stall_rs_d  = stall_rs_q + 32'd1;
      else if (decoded_bundle_fields.uses_rd && freelist_empty)      stall_prf_d = stall_prf_q + 32'd1;
    end
    if (state_q == ST_FLUSH) flush_cyc_d = flush_cyc_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_rob_q <= '0;
      stall_rs_q  <= '0;
      stall_prf_q <= '0;
      flush_cyc_q <= '0;
    end else begin
      stall_rob_q <= stall_rob_d;
      stall_rs_q  <= stall_rs_d;
      stall_prf_q <= stall_prf_d;
      flush_cyc_q <= flush_cyc_d;
    end
  end

  assign stall_rob_cnt = stall_rob_q;
  assign stall_rs_cnt  = stall_rs_q;
  assign stall_prf_cnt = stall_prf_q;
  assign flush_cyc_cnt = flush_cyc_q;
`else
  assign stall_rob_cnt = '0;
  assign stall_rs_cnt  = '0;
  assign stall_prf_cnt = '0;
  assign flush_cyc_cnt = '0;
`endif
endmodule

// File: tb/tb_dispatch_ctrl.sv
// Scoreboard bench for dispatch_ctrl: directed vectors push expected fire records, a monitor pops on every fire.
// Perf-counter expectations collapse to zero unless DISPATCH_PERF_EN is defined.
module tb_dispatch_ctrl;
  import dispatch_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            redirect_valid, decode_valid, freelist_empty;
  decoded_bundle_t bundle;
  logic            decode_ready, alu_disp_valid, br_disp_valid, lsu_disp_valid;
  logic            rob_alloc_valid, prf_alloc_valid;
  logic            alu_credit_ret, br_credit_ret, lsu_credit_ret, rob_credit_ret;
  logic [31:0]     stall_rob_cnt, stall_rs_cnt, stall_prf_cnt, flush_cyc_cnt;

  int checks = 0;
  int failures = 0;
  logic [4:0] exp_q[$];
  int alu_pulses = 0, br_pulses = 0, lsu_pulses = 0, rob_pulses = 0, prf_pulses = 0;
  int a0, b0, l0, r0;

`ifdef DISPATCH_PERF_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  dispatch_ctrl #(
    .ALU_RS_DEPTH(8), .BR_RS_DEPTH(4), .LSQ_DEPTH(8), .ROB_DEPTH(16), .FLUSH_CYCLES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .redirect_valid(redirect_valid), .decode_valid(decode_valid),
    .decoded_bundle_fields(bundle), .decode_ready(decode_ready),
    .alu_disp_valid(alu_disp_valid), .br_disp_valid(br_disp_valid), .lsu_disp_valid(lsu_disp_valid),
    .rob_alloc_valid(rob_alloc_valid), .prf_alloc_valid(prf_alloc_valid),
    .freelist_empty(freelist_empty),
    .alu_credit_ret(alu_credit_ret), .br_credit_ret(br_credit_ret),
    .lsu_credit_ret(lsu_credit_ret), .rob_credit_ret(rob_credit_ret),
    .stall_rob_cnt(stall_rob_cnt), .stall_rs_cnt(stall_rs_cnt),
    .stall_prf_cnt(stall_prf_cnt), .flush_cyc_cnt(flush_cyc_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Expected {alu, br, lsu, rob, prf} for a firing uop
  function automatic logic [4:0] steer(input logic [2:0] cls, input logic rd);
    logic [2:0] q;
    case (cls)
      3'd0:       q = 3'b100;
      3'd1, 3'd2: q = 3'b010;
      3'd3, 3'd4: q = 3'b001;
      default:    q = 3'b000;
    endcase
    return {q, 1'b1, rd};
  endfunction

  always @(negedge clk) begin
    logic [4:0] got;
    got = {alu_disp_valid, br_disp_valid, lsu_disp_valid, rob_alloc_valid, prf_alloc_valid};
    if (rst_n === 1'b1 && got != 5'b0) begin
      alu_pulses += int'(alu_disp_valid);
      br_pulses  += int'(br_disp_valid);
      lsu_pulses += int'(lsu_disp_valid);
      rob_pulses += int'(rob_alloc_valid);
      prf_pulses += int'(prf_alloc_valid);
      if (exp_q.size() == 0) chk("sb_unexpected_fire", 32'(got), 32'd0);
      else                   chk("sb_fire", 32'(got), 32'(exp_q.pop_front()));
    end
  end

  task automatic cyc(input logic dv, input logic [2:0] cls, input logic rd, input logic fe,
                     input logic redir, input logic [3:0] ret, input logic exp_rdy, input string name);
    decode_valid      = dv;
    bundle.uop_class  = uop_class_e'(cls);
    bundle.uses_rd    = rd;
    freelist_empty    = fe;
    redirect_valid    = redir;
    {alu_credit_ret, br_credit_ret, lsu_credit_ret, rob_credit_ret} = ret;
    if (dv && exp_rdy) exp_q.push_back(steer(cls, rd));
    @(negedge clk);
    chk(name, 32'(decode_ready), 32'(exp_rdy));
    @(posedge clk);
    #1;
  endtask

  task automatic check_perf(input int r, input int s, input int p, input int f, input string tag);
    chk({tag, "_stall_rob"}, stall_rob_cnt, PERF_EN ? 32'(r) : 32'd0);
    chk({tag, "_stall_rs"},  stall_rs_cnt,  PERF_EN ? 32'(s) : 32'd0);
    chk({tag, "_stall_prf"}, stall_prf_cnt, PERF_EN ? 32'(p) : 32'd0);
    chk({tag, "_flush_cyc"}, flush_cyc_cnt, PERF_EN ? 32'(f) : 32'd0);
  endtask

  task automatic idle_inputs();
    decode_valid = 1'b0; redirect_valid = 1'b0; freelist_empty = 1'b0;
    bundle.uop_class = UOP_ALU; bundle.uses_rd = 1'b0;
    {alu_credit_ret, br_credit_ret, lsu_credit_ret, rob_credit_ret} = 4'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic snap();
    a0 = alu_pulses; b0 = br_pulses; l0 = lsu_pulses; r0 = rob_pulses;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values and the reset-cycle ready equation
    do_reset();
    check_perf(0, 0, 0, 0, "rst");
    chk("rst_ready", 32'(decode_ready), 32'd1);
    bundle.uses_rd = 1'b1; freelist_empty = 1'b1; #1;
    chk("rst_ready_fl_empty", 32'(decode_ready), 32'd0);
    idle_inputs(); #1;

    // Nine back-to-back ALU uops, one credit return, then same-cycle dispatch+return at credit 1
    snap();
    for (int i = 0; i < 8; i++) cyc(1, 3'd0, 0, 0, 0, 4'b0000, 1, "a_fire");
    cyc(1, 3'd0, 0, 0, 0, 4'b0000, 0, "a_stall9");
    chk("a_alu_pulses", 32'(alu_pulses - a0), 32'd8);
    chk("a_rob_pulses", 32'(rob_pulses - r0), 32'd8);
    cyc(1, 3'd0, 0, 0, 0, 4'b1000, 0, "a_ret_no_bypass");
    cyc(1, 3'd0, 0, 0, 0, 4'b0000, 1, "a_fire9");
    cyc(1, 3'd0, 0, 0, 0, 4'b0000, 0, "a_empty_again");
    cyc(0, 3'd0, 0, 0, 0, 4'b1000, 0, "b_ret_to_one");
    cyc(1, 3'd0, 0, 0, 0, 4'b1000, 1, "b_fire_and_ret");
    cyc(1, 3'd0, 0, 0, 0, 4'b0000, 1, "b_fire_next");
    cyc(1, 3'd0, 0, 0, 0, 4'b0000, 0, "b_empty");
    chk("ab_alu_pulses", 32'(alu_pulses - a0), 32'd11);
    check_perf(0, 4, 0, 0, "ab");

    // Single redirect, then a redirect that is re-asserted one cycle into FLUSH
    do_reset();
    cyc(1, 3'd0, 0, 0, 1, 4'b0000, 0, "c_r0");
    cyc(1, 3'd0, 0, 0, 0, 4'b0000, 0, "c_r1");
    cyc(1, 3'd0, 0, 0, 0, 4'b0000, 0, "c_r2");
    cyc(1, 3'd0, 0, 0, 0, 4'b0000, 1, "c_r3_resume");
    cyc(1, 3'd0, 0, 0, 1, 4'b0000, 0, "d_r0");
    cyc(1, 3'd0, 0, 0, 1, 4'b0000, 0, "d_r1_again");
    cyc(1, 3'd0, 0, 0, 0, 4'b0000, 0, "d_r2");
    cyc(1, 3'd0, 0, 0, 0, 4'b0000, 0, "d_r3");
    cyc(1, 3'd0, 0, 0, 0, 4'b0000, 1, "d_r4_resume");
    check_perf(0, 0, 0, 5, "redir");

    // Free-list gating and steering of every class
    do_reset();
    snap();
    for (int i = 0; i < 3; i++) cyc(1, 3'd0, 1, 1, 0, 4'b0000, 0, "e_prf_stall");
    check_perf(0, 0, 3, 0, "prf");
    cyc(1, 3'd0, 0, 1, 0, 4'b0000, 1, "e_nord_fire");
    cyc(1, 3'd0, 1, 0, 0, 4'b0000, 1, "e_rd_fire");
    cyc(1, 3'd1, 1, 0, 0, 4'b0000, 1, "e_branch");
    cyc(1, 3'd2, 0, 0, 0, 4'b0000, 1, "e_jump");
    cyc(1, 3'd3, 1, 0, 0, 4'b0000, 1, "e_load");
    cyc(1, 3'd4, 0, 0, 0, 4'b0000, 1, "e_store");
    cyc(1, 3'd5, 1, 0, 0, 4'b0000, 1, "e_misc");
    cyc(1, 3'd7, 0, 0, 0, 4'b0000, 1, "e_illegal");
    cyc(1, 3'd5, 1, 1, 0, 4'b0000, 0, "e_misc_prf_stall");
    chk("e_alu_pulses", 32'(alu_pulses - a0), 32'd2);
    chk("e_br_pulses",  32'(br_pulses - b0),  32'd2);
    chk("e_lsu_pulses", 32'(lsu_pulses - l0), 32'd2);
    chk("e_prf_pulses_total", 32'(prf_pulses), 32'd4);
    check_perf(0, 0, 4, 0, "cls");

    // ROB exhaustion with MISC uops, ROB cause outranks free list
    do_reset();
    snap();
    for (int i = 0; i < 16; i++) cyc(1, 3'd5, 0, 0, 0, 4'b0000, 1, "f_misc_fire");
    cyc(1, 3'd5, 0, 0, 0, 4'b0000, 0, "f_misc17_stall");
    cyc(1, 3'd0, 1, 1, 0, 4'b0000, 0, "f_rob_priority");
    chk("f_rob_pulses", 32'(rob_pulses - r0), 32'd16);
    chk("f_rs_pulses", 32'((alu_pulses - a0) + (br_pulses - b0) + (lsu_pulses - l0)), 32'd0);
    check_perf(2, 0, 0, 0, "rob");
    cyc(0, 3'd5, 0, 0, 0, 4'b0001, 0, "f_rob_ret");
    cyc(1, 3'd5, 0, 0, 0, 4'b0000, 1, "f_misc17_fire");

    // Asynchronous reset while ALU credits are gone and the FSM is flushing
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1, 3'd0, 0, 0, 0, 4'b0000, 1, "g_fire");
    cyc(1, 3'd0, 0, 0, 0, 4'b0000, 0, "g_stall");
    cyc(0, 3'd0, 0, 0, 1, 4'b0000, 0, "g_redirect");
    idle_inputs();
    #2;
    chk("g_flush_blocks", 32'(decode_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("g_async_ready", 32'(decode_ready), 32'd1);
    check_perf(0, 0, 0, 0, "g_async");
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    snap();
    for (int i = 0; i < 8; i++) cyc(1, 3'd0, 0, 0, 0, 4'b0000, 1, "g_refire");
    cyc(1, 3'd0, 0, 0, 0, 4'b0000, 0, "g_restall");
    chk("g_alu_pulses", 32'(alu_pulses - a0), 32'd8);
    check_perf(0, 1, 0, 0, "g_end");

    idle_inputs();
    @(negedge clk);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
